sm_regdump_uart: RTL

- Reader for the CPU register debug port. Drives regAddr and captures regData.
- On a start request it walks registers 0..REG_COUNT-1 and transmits each one as an ASCII line over a UART TX pin (8N1, LSB first, idle high).
- Sits in the top level beside the CPU. It replaces switch-driven regAddr with an automatic serial dump to a host terminal.

---
 rtl/sm_regdump_uart.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sm_regdump_uart.sv
// Register debug-port dumper: walks regAddr 0..REG_COUNT-1, captures regData and
// prints each register as "AA:DDDDDDDD\r\n" on an 8N1 UART TX line.
module sm_regdump_uart #(
  parameter int BAUD_DIV  = 434,
  parameter int SETTLE    = 4,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_NEXTCH = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic [BW-1:0] baud_q,   baud_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    bit_q,    bit_d;
  logic [3:0]    char_q,   char_d;
  logic [4:0]    addr_q,   addr_d;
  logic [31:0]   data_q,   data_d;
  logic          tx_q,     tx_d;
  logic          busy_q,   busy_d;

  logic [7:0]    cur_char_s;
  logic          next_tx_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      hex_char = 8'h30 + {4'h0, n};
    end else begin
      hex_char = 8'h37 + {4'h0, n};
    end
  endfunction

  function automatic logic [7:0] line_char(input logic [3:0] idx, input logic [4:0] addr,
                                           input logic [31:0] data);
    case (idx)
      4'd0:    line_char = hex_char({3'b000, addr[4]});
      4'd1:    line_char = hex_char(addr[3:0]);
      4'd2:    line_char = 8'h3A;
      4'd3:    line_char = hex_char(data[31:28]);
      4'd4:    line_char = hex_char(data[27:24]);
      4'd5:    line_char = hex_char(data[23:20]);
      4'd6:    line_char = hex_char(data[19:16]);
      4'd7:    line_char = hex_char(data[15:12]);
      4'd8:    line_char = hex_char(data[11:8]);
      4'd9:    line_char = hex_char(data[7:4]);
      4'd10:   line_char = hex_char(data[3:0]);
      4'd11:   line_char = 8'h0D;
      default: line_char = 8'h0A;
    endcase
  endfunction

  // Level for the bit that follows bit_q: data bits LSB first, then the stop bit.
  always_comb begin
    cur_char_s = line_char(char_q, addr_q, data_q);
    if (bit_q == 4'd8) begin
      next_tx_s = 1'b1;
    end else begin
      next_tx_s = cur_char_s[bit_q[2:0]];
    end
  end

  // Sequencer: settle, capture, frame each character back to back, advance register.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    char_d   = char_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d  = S_SETTLE;
          busy_d   = 1'b1;
          addr_d   = 5'd0;
          settle_d = '0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE)) begin
          state_d = S_SEND;
          data_d  = regData;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = 4'd0;
          char_d  = 4'd0;
        end else begin
          settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      S_SEND: begin
        if (baud_q == BW'(BAUD_DIV - 1)) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (char_q == 4'd12) begin
              char_d = 4'd0;
              tx_d   = 1'b1;
              if (addr_q == 5'(REG_COUNT - 1)) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                addr_d  = 5'd0;
              end else begin
                state_d = S_NEXTCH;
              end
            end else begin
              // Next start bit goes out on the very next cycle: no inter-character gap.
              char_d = char_q + 4'd1;
              tx_d   = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = next_tx_s;
          end
        end else begin
          baud_d = baud_q + {{(BW-1){1'b0}}, 1'b1};
        end
      end
      S_NEXTCH: begin
        state_d  = S_SETTLE;
        addr_d   = addr_q + 5'd1;
        settle_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        addr_d  = 5'd0;
      end
    endcase
  end

  // State and output registers; reset forces an idle line and aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      settle_q <= '0;
      bit_q    <= 4'd0;
      char_q   <= 4'd0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign regAddr = addr_q;
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule
